// File: rtl/sistema_timer_master.sv
// Avalon-MM initiator that programs, starts, stops and services the SISTEMA interval timer,
// counts serviced timeouts and captures counter snapshots on request.
module sistema_timer_master #(
    parameter int COUNT_W  = 16,
    parameter bit CTRL_ITO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_period,
    input  logic               cmd_continuous,
    input  logic               stop_req,
    input  logic               snap_req,
    output logic               tick,
    output logic [COUNT_W-1:0] tick_count,
    output logic               snap_valid,
    output logic [31:0]        snap_value,
    output logic               busy,
    output logic [2:0]         avm_address,
    output logic               avm_chipselect,
    output logic               avm_write_n,
    output logic [15:0]        avm_writedata,
    input  logic [15:0]        avm_readdata,
    input  logic               timer_irq,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        IDLE, WR_STOP, WR_PL, WR_PH, WR_CTRL, RUN, CLR, WR_HALT,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   period;
    logic          cont;
    logic          stop_pend, snap_pend;
    logic          bus_cs, bus_wn;
    logic [2:0]    bus_addr;
    logic [15:0]   bus_wd;

    // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and cmd_period/cmd_continuous are sampled on that edge.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cmd_valid) state_nx = WR_STOP;
            WR_STOP:   state_nx = WR_PL;
            WR_PL:     state_nx = WR_PH;
            WR_PH:     state_nx = WR_CTRL;
            WR_CTRL:   state_nx = RUN;
            RUN: begin
                if (timer_irq)      state_nx = CLR;
                else if (stop_pend) state_nx = WR_HALT;
                else if (snap_pend) state_nx = SNAP_W;
            end
            CLR:       state_nx = cont ? RUN : IDLE;
            WR_HALT:   state_nx = IDLE;
            SNAP_W:    state_nx = SNAP_RL;
            SNAP_RL:   state_nx = SNAP_RH;
            SNAP_RH:   state_nx = SNAP_DONE;
            SNAP_DONE: state_nx = RUN;
            default:   state_nx = IDLE;
        endcase
    end

    // Bus signals are decoded from the state being entered so they register alongside it.
    always_comb begin
        bus_cs   = 1'b0;
        bus_wn   = 1'b1;
        bus_addr = 3'd0;
        bus_wd   = 16'h0000;
        case (state_nx)
            WR_STOP:  begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd1; bus_wd = 16'h0008; end
            WR_PL:    begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd2; bus_wd = period[15:0]; end
            WR_PH:    begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd3; bus_wd = period[31:16]; end
            WR_CTRL:  begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = 3'd1;
                bus_wd   = {12'h000, 1'b0, 1'b1, cont, CTRL_ITO};
            end
            CLR:      begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd0; end
            WR_HALT:  begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd1; bus_wd = 16'h0008; end
            SNAP_W:   begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = 3'd4; end
            SNAP_RL:  begin bus_cs = 1'b1; bus_addr = 3'd4; end
            SNAP_RH:  begin bus_cs = 1'b1; bus_addr = 3'd5; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            period         <= 32'd0;
            cont           <= 1'b0;
            stop_pend      <= 1'b0;
            snap_pend      <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            snap_valid     <= 1'b0;
            snap_value     <= 32'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 3'd0;
            avm_writedata  <= 16'h0000;
        end else begin
            state          <= state_nx;
            avm_chipselect <= bus_cs;
            avm_write_n    <= bus_wn;
            avm_address    <= bus_addr;
            avm_writedata  <= bus_wd;
            tick           <= (state_nx == CLR);
            snap_valid     <= (state == SNAP_DONE);

            if (state == IDLE && cmd_valid) begin
                period     <= (cmd_period == 32'd0) ? 32'd1 : cmd_period;
                cont       <= cmd_continuous;
                tick_count <= '0;
                stop_pend  <= 1'b0;
                snap_pend  <= 1'b0;
            end else begin
                if (state_nx == CLR)
                    tick_count <= tick_count + COUNT_W'(1);
                // Leaving to IDLE discards anything still pending.
                if (state_nx == IDLE) begin
                    stop_pend <= 1'b0;
                    snap_pend <= 1'b0;
                end else begin
                    if (stop_req)
                        stop_pend <= 1'b1;
                    if (snap_req)
                        snap_pend <= 1'b1;
                    else if (state == SNAP_DONE)
                        snap_pend <= 1'b0;
                end
            end

            // Slave read data lags the address by one cycle.
            if (state == SNAP_RH)
                snap_value[15:0] <= avm_readdata;
            if (state == SNAP_DONE)
                snap_value[31:16] <= avm_readdata;
        end
    end

endmodule

// File: tb/tb_sistema_timer_master.sv
// Directed bench for sistema_timer_master: a bus scoreboard checks every access against an
// expected queue, with a small registered-read timer slave model.
module tb_sistema_timer_master;

    localparam int CW = 6;  // small counter width so the wrap case is reachable quickly

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_period = 32'd0;
    logic          cmd_continuous = 1'b0;
    logic          stop_req = 1'b0;
    logic          snap_req = 1'b0;
    logic          tick;
    logic [CW-1:0] tick_count;
    logic          snap_valid;
    logic [31:0]   snap_value;
    logic          busy;
    logic [2:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [15:0]   avm_writedata;
    logic [15:0]   avm_readdata = 16'h0000;
    logic          timer_irq = 1'b0;
    logic [3:0]    dbg_state;

    sistema_timer_master #(.COUNT_W(CW), .CTRL_ITO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .stop_req(stop_req), .snap_req(snap_req),
        .tick(tick), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value), .busy(busy),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .timer_irq(timer_irq),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // slave model: registered read data for the snapshot registers
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? 16'h1234 :
                            (avm_address == 3'd5) ? 16'h0056 : 16'h0000;
    end

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int snap_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] snap_q[$];
    logic [31:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {12'h000, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] a);
        return {12'h000, 1'b1, a, 16'h0000};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (avm_chipselect) begin
            if (exp_q.size() == 0) begin
                chk("bus_extra", {31'd0, avm_chipselect}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bus", {12'h000, avm_write_n, avm_address, avm_writedata}, mon_e);
            end
        end else begin
            chk("bus_idle", {12'h000, avm_write_n, avm_address, avm_writedata},
                {12'h000, 1'b1, 3'd0, 16'h0000});
        end
        if (tick)
            tick_seen++;
        if (snap_valid) begin
            snap_seen++;
            if (snap_q.size() == 0) begin
                chk("snap_extra", {31'd0, snap_valid}, 32'd0);
            end else begin
                mon_e = snap_q.pop_front();
                chk("snap_value", snap_value, mon_e);
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic [31:0] p, input logic c);
        logic [31:0] pe;
        pe = (p == 32'd0) ? 32'd1 : p;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back(wr(3'd1, 16'h0008));
        exp_q.push_back(wr(3'd2, pe[15:0]));
        exp_q.push_back(wr(3'd3, pe[31:16]));
        exp_q.push_back(wr(3'd1, {12'h000, 1'b0, 1'b1, c, 1'b1}));
        cmd_valid = 1'b1;
        cmd_period = p;
        cmd_continuous = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("cmd_ready_prog", {31'd0, cmd_ready}, 32'd0);
            chk("busy_prog", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("state_run", {28'd0, dbg_state}, 32'd5);
    endtask

    task automatic do_irq(input int exp_cnt);
        logic found;
        found = 1'b0;
        exp_q.push_back(wr(3'd0, 16'h0000));
        @(negedge clk);
        timer_irq = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n && avm_address == 3'd0)
                found = 1'b1;
        end
        timer_irq = 1'b0;
        chk("irq_serviced", {31'd0, found}, 32'd1);
        chk("tick_pulse", {31'd0, tick}, 32'd1);
        chk("tick_count", 32'(tick_count), 32'(exp_cnt));
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cmd_ready; i++)
            @(negedge clk);
        chk("back_to_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("bus_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write_n", {31'd0, avm_write_n}, 32'd1);
        chk("rst_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_tick_count", 32'(tick_count), 32'd0);
        chk("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
        chk("rst_snap_value", snap_value, 32'd0);
        chk("rst_state", {28'd0, dbg_state}, 32'd0);
        reset = 1'b0;

        // continuous programming
        send_cmd(32'h000186A0, 1'b1);
        drain();

        // three serviced timeouts, stay in RUN
        for (int k = 1; k <= 3; k++) begin
            do_irq(k);
            repeat (10) @(negedge clk);
        end
        chk("tick_count_3", 32'(tick_count), 32'd3);
        chk("still_run", {28'd0, dbg_state}, 32'd5);
        #1;
        chk("tick_seen_3", 32'(tick_seen), 32'd3);

        // stop, then one-shot with period 0 clamped to 1
        exp_q.push_back(wr(3'd1, 16'h0008));
        pulse_stop();
        wait_ready();
        send_cmd(32'd0, 1'b0);
        do_irq(1);
        @(negedge clk);
        chk("oneshot_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("oneshot_idle_busy", {31'd0, busy}, 32'd0);
        drain();

        // snapshot
        send_cmd(32'h00000100, 1'b1);
        exp_q.push_back(wr(3'd4, 16'h0000));
        exp_q.push_back(rd(3'd4));
        exp_q.push_back(rd(3'd5));
        snap_q.push_back(32'h00561234);
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int i = 0; i < 20 && snap_seen == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("snap_seen", 32'(snap_seen), 32'd1);
        chk("snap_value_hold", snap_value, 32'h00561234);
        drain();

        // irq, stop and snap together: CLR, then halt, snap discarded
        exp_q.push_back(wr(3'd0, 16'h0000));
        exp_q.push_back(wr(3'd1, 16'h0008));
        @(negedge clk);
        timer_irq = 1'b1;
        stop_req = 1'b1;
        snap_req = 1'b1;
        @(negedge clk);
        timer_irq = 1'b0;
        stop_req = 1'b0;
        snap_req = 1'b0;
        chk("prio_clr_state", {28'd0, dbg_state}, 32'd6);
        chk("prio_tick", {31'd0, tick}, 32'd1);
        repeat (4) @(negedge clk);
        chk("prio_idle", {31'd0, cmd_ready}, 32'd1);
        repeat (6) @(negedge clk);
        #1;
        chk("snap_discarded", 32'(snap_seen), 32'd1);
        drain();

        // tick_count wrap with irq held high
        send_cmd(32'd5, 1'b1);
        for (int k = 0; k < (1 << CW); k++)
            exp_q.push_back(wr(3'd0, 16'h0000));
        @(negedge clk);
        timer_irq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400 && cnt < (1 << CW); i++) begin
            @(negedge clk);
            if (tick) begin
                cnt++;
                if (cnt == (1 << CW)) begin
                    timer_irq = 1'b0;
                    chk("tick_wrap", 32'(tick_count), 32'd0);
                    chk("tick_wrap_pulse", {31'd0, tick}, 32'd1);
                end else if (cnt == (1 << CW) - 1) begin
                    chk("tick_max", 32'(tick_count), 32'((1 << CW) - 1));
                end
            end
        end
        timer_irq = 1'b0;
        chk("wrap_ticks", 32'(cnt), 32'(1 << CW));
        drain();

        // reset during WR_PL: no further bus cycles
        exp_q.push_back(wr(3'd1, 16'h0008));
        pulse_stop();
        wait_ready();
        exp_q.push_back(wr(3'd1, 16'h0008));
        exp_q.push_back(wr(3'd2, 16'h0042));
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_period = 32'h00030042;
        cmd_continuous = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("at_wr_pl", {28'd0, dbg_state}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {28'd0, dbg_state}, 32'd0);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_cs", {31'd0, avm_chipselect}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        // final report
        chk("final_bus_q", 32'(exp_q.size()), 32'd0);
        chk("final_snap_q", 32'(snap_q.size()), 32'd0);
        chk("final_tick_seen", 32'(tick_seen), 32'd69);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
